clock_seg_encoder: RTL and testbench
====================================

// Module: clock_seg_encoder
// PURPOSE
//  Timekeeping and segment-pattern source for the VGA clock renderer.
//  - Counts HH:MM:SS.mmm from the board clock.
//  - Accepts a set-time load through a valid/ready handshake.
//  - Encodes each digit into the renderer's 7-bit segment vectors.
//  - Updates the vectors only at a frame strobe, so a frame never tears mid-scan.
// PARAMETERS
//  MS_DIV  100000  CLK cycles per millisecond tick (100 MHz board clock); must be >=2
// PORTS
//  CLK         in   1   board clock, all logic on rising edge
//  RST_BTN     in   1   asynchronous, active-high reset
//  RUN         in   1   1 = time advances; 0 = prescaler and counters hold
//  FRAME_STB   in   1   frame strobe (e.g. inverted VGA_VS_O), sampled on CLK; rising edge = snapshot
//  LOAD_VALID  in   1   set-time request
//  LOAD_READY  out  1   converter idle, can accept a load
//  LOAD_HOUR   in   5   binary hour, legal 0-23
//  LOAD_MIN    in   6   binary minute, legal 0-59
//  LOAD_SEC    in   6   binary second, legal 0-59
//  LOAD_ERR    out  1   1-cycle pulse: load accepted but out of range, discarded
//  TICK_MS     out  1   1-cycle pulse per millisecond tick
//  PM          out  1   PM flag (see CONFIGURATION)
//  hourSeg     out  14  [6:0] tens digit, [13:7] units digit
//  minSeg      out  14  same layout
//  secSeg      out  14  same layout
//  milliSeg    out  21  [6:0] hundreds, [13:7] tens, [20:14] units
// BEHAVIOUR
//  - Segment bits per digit: 0 top, 1 mid, 2 bottom, 3 left-top, 4 left-bottom,
//    5 right-top, 6 right-bottom; 1 = lit.
//  - Digit patterns 0-9: 7D 60 37 67 6A 4F 5F 61 7F 6F (hex).
//  - Reset values:
//    - all counters 0, so the display shows 00:00:00.000;
//    - hourSeg/minSeg/secSeg = 14'h3EFD; milliSeg = 21'h1F7EFD;
//    - LOAD_READY = 1; LOAD_ERR, TICK_MS, PM = 0.
//  - Prescaler:
//    - counts 0..MS_DIV-1 while RUN=1;
//    - at the terminal count it wraps to 0 and asserts TICK_MS for that same cycle.
//  - Counters are held in BCD; no divide logic. On each tick:
//    - ms 999 -> 000 carries into seconds;
//    - 59 -> 00 carries for seconds and minutes;
//    - hour 23 -> 00. 23:59:59.999 + 1 tick = 00:00:00.000.
//  - Snapshot: on a FRAME_STB 0->1 edge (registered edge detect), all four
//    segment outputs load from the current counters in the next cycle.
//    Outputs are stable at all other times.
//  - Load FSM: IDLE -> CONV -> COMMIT -> IDLE.
//    - IDLE: LOAD_READY = 1. Transfer happens when LOAD_VALID & LOAD_READY;
//      inputs are captured in that cycle.
//    - Range check at capture. If illegal: LOAD_ERR pulses the next cycle and
//      the FSM stays in IDLE.
//    - CONV: 6 cycles of parallel double-dabble binary-to-BCD on all three
//      fields; LOAD_READY = 0.
//    - COMMIT (1 cycle): loads the counters; clears ms and the prescaler to 0.
//    - Accept-to-new-time latency: 7 cycles after the transfer cycle.
//    - Counting continues on the old time during CONV. A tick in the COMMIT
//      cycle is discarded (load wins).
//    - LOAD_VALID while busy is ignored. The requester holds it until READY.
//  - Reset mid-conversion: the FSM returns to IDLE and the pending load is lost.
//  - RUN=0 does not block loads or snapshots.
// CONFIGURATION
//  - CLOCK_12H_EN defined:
//    - displayed hour maps 0->12, 1-12 unchanged, 13-23 -> h-12;
//    - PM = 1 for internal hours 12-23, and PM is captured with the snapshot;
//    - the internal counter stays 0-23, and loads remain 24-hour.
//  - CLOCK_12H_EN undefined: 24-hour display and PM tied to 0.
// TESTING  (bench uses MS_DIV=4)
//  1. Reset, then RUN=1 and 4000 cycles, then FRAME_STB pulse.
//     -> secSeg = {7D,60} (01), milliSeg = 21'h1F7EFD; TICK_MS every 4th cycle.
//  2. Load 23/59/59, run 1000 ticks, then snapshot.
//     -> 00:00:00.000; LOAD_READY low for exactly 7 cycles.
//  3. Load hour=24. -> LOAD_ERR 1-cycle pulse, time unchanged, LOAD_READY stays 1.
//  4. Counter changes with no FRAME_STB edge. -> outputs constant; they update
//     1 cycle after a strobe edge.
//  5. Assert RST_BTN during CONV. -> outputs reset values at once; LOAD_READY = 1.
//  6. CLOCK_12H_EN: load 13/05/00, then snapshot.
//     -> hourSeg = {7D,60} (01), PM = 1. Load 0 -> hourSeg shows 12, PM = 0.

Source files
------------

// File: rtl/clock_seg_encoder.sv
// clock_seg_encoder: BCD HH:MM:SS.mmm counter with a handshaked set-time loader and
// frame-strobe-synchronised 7-segment outputs. Define CLOCK_12H_EN for a 12-hour display.
module clock_seg_encoder #(
  parameter int MS_DIV = 100000
) (
  input  logic        CLK,
  input  logic        RST_BTN,
  input  logic        RUN,
  input  logic        FRAME_STB,
  input  logic        LOAD_VALID,
  output logic        LOAD_READY,
  input  logic [4:0]  LOAD_HOUR,
  input  logic [5:0]  LOAD_MIN,
  input  logic [5:0]  LOAD_SEC,
  output logic        LOAD_ERR,
  output logic        TICK_MS,
  output logic        PM,
  output logic [13:0] hourSeg,
  output logic [13:0] minSeg,
  output logic [13:0] secSeg,
  output logic [20:0] milliSeg
);
  localparam int PW = $clog2(MS_DIV);

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, COMMIT = 2'd2} state_t;

  state_t        state, next_state;
  logic [PW-1:0] presc;
  logic [3:0]    ms_h, ms_t, ms_u, sec_u, min_u, hr_u;
  logic [2:0]    sec_t, min_t;
  logic [1:0]    hr_t;
  logic [13:0]   dd_hr, dd_min, dd_sec;
  logic [2:0]    conv_cnt;
  logic          ready_r, err_r, stb_q, snap_q;
  logic          tick, take, in_range;
  logic          inc_mt, inc_mh, inc_su, inc_st, inc_nu, inc_nt, inc_h;
  logic [3:0]    disp_ht, disp_hu;
  logic          pm_now;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h7D;
      4'd1:    return 7'h60;
      4'd2:    return 7'h37;
      4'd3:    return 7'h67;
      4'd4:    return 7'h6A;
      4'd5:    return 7'h4F;
      4'd6:    return 7'h5F;
      4'd7:    return 7'h61;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // One double-dabble step on {tens, units, binary}: add 3 to digits >= 5, then shift.
  function automatic logic [13:0] dd_step(input logic [13:0] v);
    logic [3:0] t, u;
    t = (v[13:10] >= 4'd5) ? v[13:10] + 4'd3 : v[13:10];
    u = (v[9:6]   >= 4'd5) ? v[9:6]   + 4'd3 : v[9:6];
    return {t[2:0], u, v[5:0], 1'b0};
  endfunction

  function automatic logic [3:0] bump(input logic [3:0] d, input logic [3:0] last);
    return (d == last) ? 4'd0 : d + 4'd1;
  endfunction

  assign tick     = RUN & (presc == PW'(MS_DIV - 1));
  assign take     = (state == IDLE) & LOAD_VALID;
  assign in_range = (LOAD_HOUR < 5'd24) & (LOAD_MIN < 6'd60) & (LOAD_SEC < 6'd60);

  assign inc_mt = tick   & (ms_u  == 4'd9);
  assign inc_mh = inc_mt & (ms_t  == 4'd9);
  assign inc_su = inc_mh & (ms_h  == 4'd9);
  assign inc_st = inc_su & (sec_u == 4'd9);
  assign inc_nu = inc_st & (sec_t == 3'd5);
  assign inc_nt = inc_nu & (min_u == 4'd9);
  assign inc_h  = inc_nt & (min_t == 3'd5);

`ifdef CLOCK_12H_EN
  logic [4:0] hr_bin, hr_12;
  assign hr_bin  = {hr_t, 3'b000} + {2'b00, hr_t, 1'b0} + {1'b0, hr_u};
  assign hr_12   = (hr_bin == 5'd0) ? 5'd12 : (hr_bin > 5'd12) ? hr_bin - 5'd12 : hr_bin;
  assign disp_ht = (hr_12 >= 5'd10) ? 4'd1 : 4'd0;
  assign disp_hu = (hr_12 >= 5'd10) ? 4'(hr_12 - 5'd10) : hr_12[3:0];
  assign pm_now  = (hr_bin >= 5'd12);
`else
  assign disp_ht = {2'b00, hr_t};
  assign disp_hu = hr_u;
  assign pm_now  = 1'b0;
`endif

  // A tick coinciding with COMMIT is swallowed by the load, so it is not reported either.
  assign TICK_MS    = tick & (state != COMMIT);
  assign LOAD_READY = ready_r;
  assign LOAD_ERR   = err_r;

  always_ff @(posedge CLK or posedge RST_BTN) begin
    if (RST_BTN) begin
      presc <= '0;
    end else if (state == COMMIT) begin
      presc <= '0;
    end else if (RUN) begin
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST_BTN) begin
    if (RST_BTN) begin
      ms_h <= 4'd0; ms_t <= 4'd0; ms_u <= 4'd0;
      sec_t <= 3'd0; sec_u <= 4'd0; min_t <= 3'd0; min_u <= 4'd0;
      hr_t <= 2'd0; hr_u <= 4'd0;
    end else if (state == COMMIT) begin
      ms_h <= 4'd0; ms_t <= 4'd0; ms_u <= 4'd0;
      sec_t <= dd_sec[12:10]; sec_u <= dd_sec[9:6];
      min_t <= dd_min[12:10]; min_u <= dd_min[9:6];
      hr_t  <= dd_hr[11:10];  hr_u  <= dd_hr[9:6];
    end else begin
      if (tick)   ms_u  <= bump(ms_u, 4'd9);
      if (inc_mt) ms_t  <= bump(ms_t, 4'd9);
      if (inc_mh) ms_h  <= bump(ms_h, 4'd9);
      if (inc_su) sec_u <= bump(sec_u, 4'd9);
      if (inc_st) sec_t <= 3'(bump({1'b0, sec_t}, 4'd5));
      if (inc_nu) min_u <= bump(min_u, 4'd9);
      if (inc_nt) min_t <= 3'(bump({1'b0, min_t}, 4'd5));
      if (inc_h) begin
        if (hr_t == 2'd2 && hr_u == 4'd3) begin
          hr_t <= 2'd0; hr_u <= 4'd0;
        end else if (hr_u == 4'd9) begin
          hr_t <= hr_t + 2'd1; hr_u <= 4'd0;
        end else begin
          hr_u <= hr_u + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST_BTN) begin
    if (RST_BTN) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = (take & in_range) ? CONV : IDLE;
      CONV:    next_state = (conv_cnt == 3'd5) ? COMMIT : CONV;
      COMMIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST_BTN) begin
    if (RST_BTN) begin
      dd_hr <= 14'd0; dd_min <= 14'd0; dd_sec <= 14'd0;
      conv_cnt <= 3'd0; ready_r <= 1'b1; err_r <= 1'b0;
    end else begin
      ready_r <= (next_state == IDLE);
      err_r   <= take & ~in_range;
      if (take) begin
        dd_hr    <= {9'd0, LOAD_HOUR};
        dd_min   <= {8'd0, LOAD_MIN};
        dd_sec   <= {8'd0, LOAD_SEC};
        conv_cnt <= 3'd0;
      end else if (state == CONV) begin
        dd_hr    <= dd_step(dd_hr);
        dd_min   <= dd_step(dd_min);
        dd_sec   <= dd_step(dd_sec);
        conv_cnt <= conv_cnt + 3'd1;
      end
    end
  end

  // Segment outputs only move the cycle after a registered strobe rising edge.
  always_ff @(posedge CLK or posedge RST_BTN) begin
    if (RST_BTN) begin
      stb_q <= 1'b0; snap_q <= 1'b0; PM <= 1'b0;
      hourSeg <= 14'h3EFD; minSeg <= 14'h3EFD; secSeg <= 14'h3EFD;
      milliSeg <= 21'h1F7EFD;
    end else begin
      stb_q  <= FRAME_STB;
      snap_q <= FRAME_STB & ~stb_q;
      if (snap_q) begin
        hourSeg  <= {seg7(disp_hu), seg7(disp_ht)};
        minSeg   <= {seg7(min_u), seg7({1'b0, min_t})};
        secSeg   <= {seg7(sec_u), seg7({1'b0, sec_t})};
        milliSeg <= {seg7(ms_u), seg7(ms_t), seg7(ms_h)};
        PM       <= pm_now;
      end
    end
  end
endmodule

// File: tb/tb_clock_seg_encoder.sv
// Bench for clock_seg_encoder at MS_DIV=4: load table, directed corner sequences and
// randomized stimulus, all checked against a milliseconds-of-day reference model.
`timescale 1ns/1ps
module tb_clock_seg_encoder;
  localparam int MS_DIV = 4;
  localparam int DAY_MS = 86400000;

  logic        clk = 1'b0;
  logic        rst_btn, run, frame_stb, load_valid;
  logic        load_ready, load_err, tick_ms, pm;
  logic [4:0]  load_hour;
  logic [5:0]  load_min, load_sec;
  logic [13:0] hour_seg, min_seg, sec_seg;
  logic [20:0] milli_seg;

  clock_seg_encoder #(.MS_DIV(MS_DIV)) dut (
    .CLK(clk), .RST_BTN(rst_btn), .RUN(run), .FRAME_STB(frame_stb),
    .LOAD_VALID(load_valid), .LOAD_READY(load_ready), .LOAD_HOUR(load_hour),
    .LOAD_MIN(load_min), .LOAD_SEC(load_sec), .LOAD_ERR(load_err), .TICK_MS(tick_ms),
    .PM(pm), .hourSeg(hour_seg), .minSeg(min_seg), .secSeg(sec_seg), .milliSeg(milli_seg)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model: time as milliseconds since midnight
  int now_ms, presc, busy_left, pending_ms, disp_ms;
  bit err_q, stb_prev, snap_pend, disp_is_reset;
  logic [6:0] pats [10];

  typedef struct {
    int h; int m; int s; bit err;
    logic [13:0] hseg24; logic [13:0] hseg12; bit pm12;
    logic [13:0] mseg; logic [13:0] sseg;
  } load_vec_t;
  load_vec_t tbl [7];

  function automatic logic [13:0] seg2(input int v);
    return {pats[v % 10], pats[v / 10]};
  endfunction

  function automatic logic [13:0] exp_hour_seg();
    int h;
    if (disp_is_reset) return 14'h3EFD;
    h = disp_ms / 3600000;
`ifdef CLOCK_12H_EN
    h = (h % 12 == 0) ? 12 : h % 12;
`endif
    return seg2(h);
  endfunction

  function automatic logic [20:0] exp_milli_seg();
    int v;
    v = disp_ms % 1000;
    return {pats[v % 10], pats[(v / 10) % 10], pats[v / 100]};
  endfunction

  function automatic bit exp_pm();
`ifdef CLOCK_12H_EN
    return !disp_is_reset && (disp_ms / 3600000 >= 12);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    now_ms = 0; presc = 0; busy_left = 0; pending_ms = 0; disp_ms = 0;
    err_q = 0; stb_prev = 0; snap_pend = 0; disp_is_reset = 1;
  endtask

  task automatic model_edge();
    bit commit;
    commit = (busy_left == 1);
    if (snap_pend) begin
      disp_ms = now_ms;
      disp_is_reset = 0;
    end
    snap_pend = frame_stb && !stb_prev;
    stb_prev  = frame_stb;
    if (commit) begin
      now_ms = pending_ms;
      presc  = 0;
    end else if (run) begin
      if (presc == MS_DIV - 1) begin
        presc  = 0;
        now_ms = (now_ms + 1) % DAY_MS;
      end else begin
        presc++;
      end
    end
    err_q = 0;
    if (busy_left > 0) begin
      busy_left--;
    end else if (load_valid) begin
      if (int'(load_hour) < 24 && int'(load_min) < 60 && int'(load_sec) < 60) begin
        pending_ms = ((int'(load_hour) * 60 + int'(load_min)) * 60 + int'(load_sec)) * 1000;
        busy_left  = 7;
      end else begin
        err_q = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("ready", load_ready, busy_left == 0);
    chk("err", load_err, err_q);
    chk("tick", tick_ms, run && presc == MS_DIV - 1 && busy_left != 1);
    chk("pm", pm, exp_pm());
    chk("hourSeg", hour_seg, exp_hour_seg());
    chk("minSeg", min_seg, seg2((disp_ms / 60000) % 60));
    chk("secSeg", sec_seg, seg2((disp_ms / 1000) % 60));
    chk("milliSeg", milli_seg, exp_milli_seg());
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_btn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_btn = 1'b0;
    model_reset();
    check_all();
  endtask

  task automatic load(input int h, input int m, input int s);
    load_hour = 5'(h); load_min = 6'(m); load_sec = 6'(s);
    load_valid = 1'b1;
    cycle();
    load_valid = 1'b0;
  endtask

  task automatic snapshot();
    frame_stb = 1'b1;
    cycle();
    frame_stb = 1'b0;
    cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks, low;
    pats = '{7'h7D, 7'h60, 7'h37, 7'h67, 7'h6A, 7'h4F, 7'h5F, 7'h61, 7'h7F, 7'h6F};
    tbl[0] = '{23, 59, 59, 1'b0, 14'h33B7, 14'h3060, 1'b1, 14'h37CF, 14'h37CF};
    tbl[1] = '{10,  7, 42, 1'b0, 14'h3EE0, 14'h3EE0, 1'b0, 14'h30FD, 14'h1BEA};
    tbl[2] = '{24,  0,  0, 1'b1, 14'h0000, 14'h0000, 1'b0, 14'h0000, 14'h0000};
    tbl[3] = '{13,  5,  0, 1'b0, 14'h33E0, 14'h307D, 1'b1, 14'h27FD, 14'h3EFD};
    tbl[4] = '{ 0,  0,  0, 1'b0, 14'h3EFD, 14'h1BE0, 1'b0, 14'h3EFD, 14'h3EFD};
    tbl[5] = '{12, 60,  0, 1'b1, 14'h0000, 14'h0000, 1'b0, 14'h0000, 14'h0000};
    tbl[6] = '{ 5, 30, 59, 1'b0, 14'h27FD, 14'h27FD, 1'b0, 14'h3EE7, 14'h37CF};

    run = 1'b0; frame_stb = 1'b0; load_valid = 1'b0;
    load_hour = 5'd0; load_min = 6'd0; load_sec = 6'd0;
    do_reset();
    chk("reset_milli", milli_seg, 21'h1F7EFD);
    chk("reset_ready", load_ready, 1'b1);

    // 4000 running cycles = exactly 1000 ticks = 1.000 s
    run = 1'b1;
    ticks = 0;
    for (int i = 0; i < 4000; i++) begin
      cycle();
      if (tick_ms) ticks++;
    end
    chk("tick_count", ticks, 1000);
    run = 1'b0;
    snapshot();
    chk("one_sec", sec_seg, 14'h307D);
    chk("one_sec_ms", milli_seg, 21'h1F7EFD);

    for (int i = 0; i < 7; i++) begin
      load(tbl[i].h, tbl[i].m, tbl[i].s);
      chk("tbl_err", load_err, tbl[i].err);
      low = 0;
      for (int c = 0; c < 10; c++) begin
        if (!load_ready) low++;
        cycle();
      end
      chk("tbl_ready_low", low, tbl[i].err ? 0 : 7);
      snapshot();
      if (!tbl[i].err) begin
`ifdef CLOCK_12H_EN
        chk("tbl_hour", hour_seg, tbl[i].hseg12);
        chk("tbl_pm", pm, tbl[i].pm12);
`else
        chk("tbl_hour", hour_seg, tbl[i].hseg24);
        chk("tbl_pm", pm, 1'b0);
`endif
        chk("tbl_min", min_seg, tbl[i].mseg);
        chk("tbl_sec", sec_seg, tbl[i].sseg);
        chk("tbl_milli", milli_seg, 21'h1F7EFD);
      end
    end

    // midnight rollover: 23:59:59.000 + 1000 ticks
    load(23, 59, 59);
    repeat (8) cycle();
    run = 1'b1;
    repeat (4000) cycle();
    run = 1'b0;
    snapshot();
`ifdef CLOCK_12H_EN
    chk("wrap_hour", hour_seg, 14'h1BE0);
`else
    chk("wrap_hour", hour_seg, 14'h3EFD);
`endif
    chk("wrap_min", min_seg, 14'h3EFD);
    chk("wrap_sec", sec_seg, 14'h3EFD);
    chk("wrap_milli", milli_seg, 21'h1F7EFD);
    chk("wrap_pm", pm, 1'b0);

    // counters move without a strobe edge; display must hold until one
    run = 1'b1;
    repeat (50) cycle();
    chk("hold_milli", milli_seg, 21'h1F7EFD);
    frame_stb = 1'b1;
    cycle();
    chk("stb_not_yet", milli_seg, 21'h1F7EFD);
    cycle();
    chk("stb_update", milli_seg, 21'h0DF07D);
    repeat (20) cycle();
    chk("stb_level_hold", milli_seg, 21'h0DF07D);
    frame_stb = 1'b0;
    run = 1'b0;
    cycle();

    // reset in the middle of a conversion drops the load
    load(1, 2, 3);
    cycle();
    cycle();
    #2 rst_btn = 1'b1;
    #1;
    chk("rst_hour", hour_seg, 14'h3EFD);
    chk("rst_sec", sec_seg, 14'h3EFD);
    chk("rst_milli", milli_seg, 21'h1F7EFD);
    chk("rst_ready", load_ready, 1'b1);
    chk("rst_pm", pm, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_btn = 1'b0;
    model_reset();
    check_all();
    repeat (10) cycle();
    snapshot();
    chk("rst_load_lost", min_seg, 14'h3EFD);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      run = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) frame_stb = ~frame_stb;
      load_valid = ($urandom_range(0, 63) == 0);
      load_hour  = 5'($urandom_range(0, 25));
      load_min   = 6'($urandom_range(0, 61));
      load_sec   = 6'($urandom_range(0, 61));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
